// File: rtl/rename_map_stage.sv
// Rename stage: speculative and retirement register alias tables, free-list
// allocation, intra-group RAW/WAW bypass and a registered valid/ready output.
module rename_map_stage #(
    parameter int WIDTH = 4,
    parameter int AREG  = 5,
    parameter int PREG  = 7
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [WIDTH-1:0]        in_instv_i,
    input  logic [WIDTH-1:0]        in_rdwe_i,
    input  logic [WIDTH*AREG-1:0]   in_rs1_i,
    input  logic [WIDTH*AREG-1:0]   in_rs2_i,
    input  logic [WIDTH*AREG-1:0]   in_rd_i,
    input  logic                    fl_avail_i,
    input  logic [WIDTH*PREG-1:0]   fl_phys_i,
    output logic [WIDTH-1:0]        fl_pop_o,
    input  logic [WIDTH-1:0]        cm_valid_i,
    input  logic [WIDTH*AREG-1:0]   cm_rd_i,
    input  logic [WIDTH*PREG-1:0]   cm_rdphys_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [WIDTH-1:0]        out_instv_o,
    output logic [WIDTH*PREG-1:0]   out_rs1phys_o,
    output logic [WIDTH*PREG-1:0]   out_rs2phys_o,
    output logic [WIDTH*PREG-1:0]   out_rdphys_o,
    output logic [WIDTH*PREG-1:0]   out_oldrdphys_o
);

    localparam int              NAREG   = 1 << AREG;
    localparam logic [AREG-1:0] ZR      = '1;
    localparam logic [PREG-1:0] ZR_PHYS = PREG'(ZR);

    logic [PREG-1:0] spec_rat_q [NAREG];
    logic [PREG-1:0] spec_rat_d [NAREG];
    logic [PREG-1:0] ret_rat_q  [NAREG];
    logic [PREG-1:0] ret_rat_d  [NAREG];

    logic                  out_valid_q;
    logic [WIDTH-1:0]      out_instv_q;
    logic [WIDTH*PREG-1:0] out_rs1_q, out_rs2_q, out_rd_q, out_old_q;

    logic                  fire;
    logic [WIDTH-1:0]      alloc;
    logic [WIDTH*PREG-1:0] rs1_d, rs2_d, rd_d, old_d;

    assign in_ready_o = (~out_valid_q | out_ready_i) & fl_avail_i & ~flush_i;
    assign fire       = in_valid_i & in_ready_o;
    assign fl_pop_o   = fire ? alloc : '0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slot
            logic [AREG-1:0] rs1_a, rs2_a, rd_a;
            logic [PREG-1:0] rs1_p, rs2_p, old_p;

            assign rs1_a     = in_rs1_i[gi*AREG +: AREG];
            assign rs2_a     = in_rs2_i[gi*AREG +: AREG];
            assign rd_a      = in_rd_i[gi*AREG +: AREG];
            assign alloc[gi] = in_instv_i[gi] & in_rdwe_i[gi] & (rd_a != ZR);

            // Table lookup, overridden by the youngest older slot writing the same reg
            always_comb begin
                rs1_p = spec_rat_q[rs1_a];
                rs2_p = spec_rat_q[rs2_a];
                old_p = spec_rat_q[rd_a];
                for (int j = 0; j < gi; j++) begin
                    if (alloc[j] && in_rd_i[j*AREG +: AREG] == rs1_a) rs1_p = fl_phys_i[j*PREG +: PREG];
                    if (alloc[j] && in_rd_i[j*AREG +: AREG] == rs2_a) rs2_p = fl_phys_i[j*PREG +: PREG];
                    if (alloc[j] && in_rd_i[j*AREG +: AREG] == rd_a)  old_p = fl_phys_i[j*PREG +: PREG];
                end
                if (rs1_a == ZR) rs1_p = ZR_PHYS;
                if (rs2_a == ZR) rs2_p = ZR_PHYS;
                if (rd_a == ZR)  old_p = ZR_PHYS;
            end

            assign rs1_d[gi*PREG +: PREG] = rs1_p;
            assign rs2_d[gi*PREG +: PREG] = rs2_p;
            assign old_d[gi*PREG +: PREG] = old_p;
            assign rd_d[gi*PREG +: PREG]  = alloc[gi] ? fl_phys_i[gi*PREG +: PREG] : old_p;
        end
    endgenerate

    // Retirement table absorbs this cycle's commits; later slots override earlier ones
    always_comb begin
        ret_rat_d = ret_rat_q;
        for (int k = 0; k < WIDTH; k++) begin
            if (cm_valid_i[k] && cm_rd_i[k*AREG +: AREG] != ZR)
                ret_rat_d[cm_rd_i[k*AREG +: AREG]] = cm_rdphys_i[k*PREG +: PREG];
        end
    end

    // Speculative table: restored from the updated retirement table on flush,
    // otherwise takes the group's allocations when the group is accepted
    always_comb begin
        spec_rat_d = spec_rat_q;
        if (flush_i) begin
            spec_rat_d = ret_rat_d;
        end else if (fire) begin
            for (int k = 0; k < WIDTH; k++) begin
                if (alloc[k]) spec_rat_d[in_rd_i[k*AREG +: AREG]] = fl_phys_i[k*PREG +: PREG];
            end
        end
    end

    // Both tables reset to the identity mapping
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NAREG; i++) begin
                spec_rat_q[i] <= PREG'(i);
                ret_rat_q[i]  <= PREG'(i);
            end
        end else begin
            spec_rat_q <= spec_rat_d;
            ret_rat_q  <= ret_rat_d;
        end
    end

    // Output register: load on accept, drop on flush or drain, hold while stalled
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_instv_q <= '0;
            out_rs1_q   <= '0;
            out_rs2_q   <= '0;
            out_rd_q    <= '0;
            out_old_q   <= '0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
        end else if (fire) begin
            out_valid_q <= 1'b1;
            out_instv_q <= in_instv_i;
            out_rs1_q   <= rs1_d;
            out_rs2_q   <= rs2_d;
            out_rd_q    <= rd_d;
            out_old_q   <= old_d;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid_o     = out_valid_q;
    assign out_instv_o     = out_instv_q;
    assign out_rs1phys_o   = out_rs1_q;
    assign out_rs2phys_o   = out_rs2_q;
    assign out_rdphys_o    = out_rd_q;
    assign out_oldrdphys_o = out_old_q;

endmodule

// File: tb/tb_rename_map_stage.sv
// Randomised and directed checks of rename_map_stage against a sequential
// instruction-by-instruction rename model.
module tb_rename_map_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, fl_avail, out_valid, out_ready;
    logic [3:0]  in_instv, in_rdwe, fl_pop, cm_valid, out_instv;
    logic [19:0] in_rs1, in_rs2, in_rd, cm_rd;
    logic [27:0] fl_phys, cm_rdphys, out_rs1, out_rs2, out_rd, out_old;

    always #5 clk = ~clk;

    rename_map_stage #(.WIDTH(4), .AREG(5), .PREG(7)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_instv_i(in_instv), .in_rdwe_i(in_rdwe),
        .in_rs1_i(in_rs1), .in_rs2_i(in_rs2), .in_rd_i(in_rd),
        .fl_avail_i(fl_avail), .fl_phys_i(fl_phys), .fl_pop_o(fl_pop),
        .cm_valid_i(cm_valid), .cm_rd_i(cm_rd), .cm_rdphys_i(cm_rdphys),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_instv_o(out_instv),
        .out_rs1phys_o(out_rs1), .out_rs2phys_o(out_rs2),
        .out_rdphys_o(out_rd), .out_oldrdphys_o(out_old)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state
    logic [6:0]  m_spec [32];
    logic [6:0]  m_ret  [32];
    logic        m_valid;
    logic [3:0]  e_instv;
    logic [27:0] e_rs1, e_rs2, e_rd, e_old;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_spec[i] = 7'(i);
            m_ret[i]  = 7'(i);
        end
        m_valid = 1'b0;
        e_instv = '0; e_rs1 = '0; e_rs2 = '0; e_rd = '0; e_old = '0;
    endtask

    task automatic clear_in();
        rst = 0; flush = 0; in_valid = 0; in_instv = '0; in_rdwe = '0;
        in_rs1 = '0; in_rs2 = '0; in_rd = '0; fl_avail = 1; out_ready = 1;
        fl_phys = {7'd35, 7'd34, 7'd33, 7'd32};
        cm_valid = '0; cm_rd = '0; cm_rdphys = '0;
    endtask

    task automatic set_slot(input int k, input logic wr, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [4:0] rd, input logic [6:0] fl);
        in_instv[k] = 1'b1;
        in_rdwe[k]  = wr;
        in_rs1[k*5 +: 5]  = rs1;
        in_rs2[k*5 +: 5]  = rs2;
        in_rd[k*5 +: 5]   = rd;
        fl_phys[k*7 +: 7] = fl;
    endtask

    // One clock: check handshake/pops against the model, clock, then check outputs
    task automatic step();
        logic [6:0]  tmp [32];
        logic [3:0]  alloc;
        logic        exp_ready, fire;
        logic [27:0] n_rs1, n_rs2, n_rd, n_old;
        logic [4:0]  a1, a2, ad;
        #1;
        exp_ready = (!m_valid || out_ready) && fl_avail && !flush;
        fire  = in_valid && exp_ready;
        alloc = '0;
        tmp   = m_spec;
        n_rs1 = '0; n_rs2 = '0; n_rd = '0; n_old = '0;
        // Rename each instruction in program order against a running map
        for (int k = 0; k < 4; k++) begin
            a1 = in_rs1[k*5 +: 5];
            a2 = in_rs2[k*5 +: 5];
            ad = in_rd[k*5 +: 5];
            n_rs1[k*7 +: 7] = (a1 == 5'd31) ? 7'd31 : tmp[a1];
            n_rs2[k*7 +: 7] = (a2 == 5'd31) ? 7'd31 : tmp[a2];
            n_old[k*7 +: 7] = (ad == 5'd31) ? 7'd31 : tmp[ad];
            if (in_instv[k] && in_rdwe[k] && ad != 5'd31) begin
                alloc[k] = 1'b1;
                tmp[ad]  = fl_phys[k*7 +: 7];
                n_rd[k*7 +: 7] = fl_phys[k*7 +: 7];
            end else begin
                n_rd[k*7 +: 7] = n_old[k*7 +: 7];
            end
        end
        check("in_ready", 64'(in_ready), 64'(exp_ready));
        check("fl_pop", 64'(fl_pop), 64'(fire ? alloc : 4'b0));
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < 4; k++)
                if (cm_valid[k] && cm_rd[k*5 +: 5] != 5'd31)
                    m_ret[cm_rd[k*5 +: 5]] = cm_rdphys[k*7 +: 7];
            if (flush) begin
                m_spec  = m_ret;
                m_valid = 1'b0;
            end else if (fire) begin
                m_spec  = tmp;
                m_valid = 1'b1;
                e_instv = in_instv; e_rs1 = n_rs1; e_rs2 = n_rs2; e_rd = n_rd; e_old = n_old;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
        check("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            check("out_instv", 64'(out_instv), 64'(e_instv));
            check("out_rs1", 64'(out_rs1), 64'(e_rs1));
            check("out_rs2", 64'(out_rs2), 64'(e_rs2));
            check("out_rd", 64'(out_rd), 64'(e_rd));
            check("out_old", 64'(out_old), 64'(e_old));
        end
        $display("cyc rst=%0b fl=%0b iv=%0b fire=%0b pop=%b ov=%0b", rst, flush, in_valid, fire, fl_pop, out_valid);
    endtask

    function automatic logic [4:0] pick_reg();
        int r;
        r = $urandom_range(0, 9);
        return (r == 9) ? 5'd31 : 5'(r);
    endfunction

    logic [27:0] hold_rs1, hold_rd;

    initial begin
        clear_in();
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_rs1", 64'(out_rs1), 64'd0);
        check("rst_old", 64'(out_old), 64'd0);
        check("rst_instv", 64'(out_instv), 64'd0);

        // Identity mapping, no writes
        clear_in(); in_valid = 1;
        for (int k = 0; k < 4; k++) set_slot(k, 0, 5'(k + 1), 5'd0, 5'd0, 7'(40 + k));
        step();
        check("ident_rs1", 64'(out_rs1), 64'({7'd4, 7'd3, 7'd2, 7'd1}));

        // RAW/WAW chain through arch reg 5
        clear_in(); in_valid = 1;
        set_slot(0, 1, 5'd0, 5'd0, 5'd5, 7'd40);
        set_slot(1, 1, 5'd5, 5'd0, 5'd5, 7'd41);
        set_slot(2, 0, 5'd5, 5'd5, 5'd0, 7'd42);
        set_slot(3, 1, 5'd0, 5'd0, 5'd5, 7'd43);
        #1;
        check("chain_pop", 64'(fl_pop), 64'(4'b1011));
        step();
        check("chain_s0_old", 64'(out_old[0 +: 7]), 64'd5);
        check("chain_s1_rs1", 64'(out_rs1[7 +: 7]), 64'd40);
        check("chain_s1_old", 64'(out_old[7 +: 7]), 64'd40);
        check("chain_s2_rs1", 64'(out_rs1[14 +: 7]), 64'd41);
        check("chain_s2_rs2", 64'(out_rs2[14 +: 7]), 64'd41);
        check("chain_s3_old", 64'(out_old[21 +: 7]), 64'd41);
        clear_in(); in_valid = 1;
        set_slot(0, 0, 5'd5, 5'd0, 5'd0, 7'd44);
        step();
        check("chain_next", 64'(out_rs1[0 +: 7]), 64'd43);

        // Zero register as destination and source
        clear_in(); in_valid = 1;
        set_slot(0, 1, 5'd0, 5'd0, 5'd31, 7'd70);
        set_slot(1, 0, 5'd31, 5'd0, 5'd0, 7'd71);
        #1;
        check("zr_pop0", 64'(fl_pop[0]), 64'd0);
        step();
        check("zr_rd", 64'(out_rd[0 +: 7]), 64'd31);
        check("zr_old", 64'(out_old[0 +: 7]), 64'd31);
        check("zr_rs1", 64'(out_rs1[7 +: 7]), 64'd31);

        // Backpressure
        clear_in(); in_valid = 1;
        set_slot(0, 1, 5'd1, 5'd2, 5'd3, 7'd80);
        step();
        hold_rs1 = out_rs1; hold_rd = out_rd;
        set_slot(0, 1, 5'd3, 5'd3, 5'd4, 7'd81);
        out_ready = 0;
        for (int c = 0; c < 2; c++) begin
            #1;
            check("bp_ready", 64'(in_ready), 64'd0);
            check("bp_pop", 64'(fl_pop), 64'd0);
            step();
            check("bp_hold_rs1", 64'(out_rs1), 64'(hold_rs1));
            check("bp_hold_rd", 64'(out_rd), 64'(hold_rd));
        end
        out_ready = 1; in_valid = 0;
        step();
        fl_avail = 0; in_valid = 1;
        #1;
        check("fl_empty_ready", 64'(in_ready), 64'd0);
        step();

        // Flush restores from retirement table
        clear_in(); in_valid = 1;
        set_slot(0, 1, 5'd0, 5'd0, 5'd7, 7'd50);
        step();
        clear_in(); flush = 1;
        step();
        clear_in(); in_valid = 1;
        set_slot(0, 0, 5'd7, 5'd0, 5'd0, 7'd51);
        step();
        check("flush_rs1", 64'(out_rs1[0 +: 7]), 64'd7);
        clear_in(); in_valid = 1;
        set_slot(0, 1, 5'd0, 5'd0, 5'd7, 7'd50);
        step();
        clear_in(); flush = 1;
        cm_valid = 4'b0001; cm_rd[0 +: 5] = 5'd7; cm_rdphys[0 +: 7] = 7'd50;
        step();
        clear_in(); in_valid = 1;
        set_slot(0, 0, 5'd7, 5'd0, 5'd0, 7'd52);
        step();
        check("flush_cm_rs1", 64'(out_rs1[0 +: 7]), 64'd50);

        // Commit collision: youngest commit slot wins
        clear_in(); flush = 1;
        cm_valid = 4'b0101;
        cm_rd[0 +: 5] = 5'd9;  cm_rdphys[0 +: 7]  = 7'd60;
        cm_rd[10 +: 5] = 5'd9; cm_rdphys[14 +: 7] = 7'd62;
        step();
        clear_in(); in_valid = 1;
        set_slot(0, 0, 5'd9, 5'd0, 5'd0, 7'd53);
        step();
        check("cm_coll_rs1", 64'(out_rs1[0 +: 7]), 64'd62);

        // Reset in the middle of a group
        clear_in(); in_valid = 1; rst = 1;
        set_slot(0, 1, 5'd0, 5'd0, 5'd7, 7'd99);
        step();
        check("midrst_valid", 64'(out_valid), 64'd0);
        clear_in(); in_valid = 1;
        set_slot(0, 0, 5'd7, 5'd9, 5'd0, 7'd54);
        step();
        check("midrst_map", 64'({out_rs2[0 +: 7], out_rs1[0 +: 7]}), 64'({7'd9, 7'd7}));

        // Randomised traffic
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            fl_avail  = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 4; k++) begin
                in_instv[k]         = ($urandom_range(0, 4) != 0);
                in_rdwe[k]          = ($urandom_range(0, 2) != 0);
                in_rs1[k*5 +: 5]    = pick_reg();
                in_rs2[k*5 +: 5]    = pick_reg();
                in_rd[k*5 +: 5]     = pick_reg();
                fl_phys[k*7 +: 7]   = 7'($urandom_range(32, 127));
                cm_valid[k]         = ($urandom_range(0, 2) == 0);
                cm_rd[k*5 +: 5]     = pick_reg();
                cm_rdphys[k*7 +: 7] = 7'($urandom_range(0, 127));
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
